// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with frame-latched value,
// leading-zero blanking, anti-ghosting guard gap and 8-level PWM brightness.
module sseg_scan_driver #(
  parameter int SLOT_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value_i,
  input  logic        blank_lz_i,
  input  logic [2:0]  bright_i,
  input  logic        enable_i,
  output logic [6:0]  seg_n_o,
  output logic [3:0]  an_n_o,
  output logic        frame_o
);

  localparam logic [15:0] SLOT_LAST = 16'(SLOT_CYCLES - 1);
  localparam logic [15:0] GUARD     = 16'(GUARD_CYCLES);

  logic [15:0] slot_cnt;
  logic [1:0]  dig;
  logic [2:0]  pwm_cnt;
  logic [15:0] shadow;
  logic        lz_q;

  logic        slot_wrap;
  logic        frame_edge;
  logic        upper_zero;
  logic        lit;
  logic [3:0]  nib;
  logic [3:0]  an_sel;
  logic [6:0]  glyph;

  assign slot_wrap  = slot_cnt == SLOT_LAST;
  assign frame_edge = slot_wrap && dig == 2'd3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt <= '0;
      dig      <= '0;
      pwm_cnt  <= '0;
      shadow   <= '0;
      lz_q     <= 1'b0;
    end else begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + 16'd1;
      pwm_cnt  <= pwm_cnt + 3'd1;
      if (slot_wrap) begin
        dig <= dig + 2'd1;
      end
      // Latch only at the frame edge so a frame never mixes two values
      if (frame_edge) begin
        shadow <= value_i;
        lz_q   <= blank_lz_i;
      end
    end
  end

  always_comb begin
    nib        = shadow[3:0];
    upper_zero = 1'b0;
    an_sel     = 4'b1110;
    unique case (dig)
      2'd0: begin
        nib        = shadow[3:0];
        upper_zero = 1'b0;
        an_sel     = 4'b1110;
      end
      2'd1: begin
        nib        = shadow[7:4];
        upper_zero = shadow[15:4] == 12'd0;
        an_sel     = 4'b1101;
      end
      2'd2: begin
        nib        = shadow[11:8];
        upper_zero = shadow[15:8] == 8'd0;
        an_sel     = 4'b1011;
      end
      2'd3: begin
        nib        = shadow[15:12];
        upper_zero = shadow[15:12] == 4'd0;
        an_sel     = 4'b0111;
      end
    endcase
  end

  always_comb begin
    glyph = 7'h7F;
    unique case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
    endcase
  end

  assign lit = enable_i
            && !(lz_q && upper_zero)
            && slot_cnt >= GUARD
            && pwm_cnt <= bright_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_n_o  <= 4'hF;
      seg_n_o <= 7'h7F;
      frame_o <= 1'b0;
    end else begin
      an_n_o  <= lit ? an_sel : 4'hF;
      seg_n_o <= lit ? glyph : 7'h7F;
      frame_o <= frame_edge;
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Randomized bench for sseg_scan_driver against a cycle-index reference model.
// Expected outputs derive from elapsed cycles since reset via plain arithmetic.
module tb_sseg_scan_driver;

  localparam int SLOT  = 16;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] value = 16'h0;
  logic        blank_lz = 1'b0;
  logic [2:0]  bright = 3'd7;
  logic        enable = 1'b1;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame;

  int checks = 0;
  int failures = 0;

  sseg_scan_driver #(
    .SLOT_CYCLES (SLOT),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .value_i   (value),
    .blank_lz_i(blank_lz),
    .bright_i  (bright),
    .enable_i  (enable),
    .seg_n_o   (seg_n),
    .an_n_o    (an_n),
    .frame_o   (frame)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Reference model: n = cycles elapsed since reset release
  int          n = 0;
  logic [15:0] m_shadow = 16'h0;
  logic        m_lz = 1'b0;
  logic [3:0]  exp_an = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_frame = 1'b0;
  int          m_slot, m_dig, m_pwm;
  logic        m_blank, m_on, m_bound;

  always_comb begin
    m_slot  = n % SLOT;
    m_dig   = (n / SLOT) % 4;
    m_pwm   = n % 8;
    m_blank = !enable ||
              (m_lz && m_dig != 0 && (m_shadow >> (4 * m_dig)) == 16'd0);
    m_on    = !m_blank && m_slot >= GUARD && m_pwm <= int'(bright);
    m_bound = m_slot == SLOT - 1 && m_dig == 3;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n         <= 0;
      m_shadow  <= 16'h0;
      m_lz      <= 1'b0;
      exp_an    <= 4'hF;
      exp_seg   <= 7'h7F;
      exp_frame <= 1'b0;
    end else begin
      n         <= n + 1;
      exp_an    <= m_on ? ~(4'b0001 << m_dig) : 4'hF;
      exp_seg   <= m_on ? glyph_tab[m_shadow[4*m_dig +: 4]] : 7'h7F;
      exp_frame <= m_bound;
      if (m_bound) begin
        m_shadow <= value;
        m_lz     <= blank_lz;
      end
    end
  end

  always @(negedge clk) begin
    assert ($countones(~an_n) <= 1)
    else begin
      failures++;
      $display("FAIL onehot an_n=%h required at most one low bit", an_n);
    end
  end

  // Park on the negedge where the upcoming posedge is a frame boundary
  task automatic sync_boundary();
    for (int i = 0; i < 2 * FRAME && (n % FRAME) != FRAME - 1; i++)
      @(negedge clk);
    if ((n % FRAME) != FRAME - 1) begin
      failures++;
      $display("FAIL sync_boundary timeout n=%0d", n);
    end
  endtask

  task automatic test_reset();
    int first_frame;
    int low_cnt [4];
    logic [3:0] an_seen [4];
    logic [6:0] seg_seen [4];
    logic [3:0] an_req [4];
    logic [6:0] seg_req [4];
    an_req  = '{4'hE, 4'hD, 4'hB, 4'h7};
    seg_req = '{7'h0E, 7'h08, 7'h24, 7'h79};
    reset_n = 1'b0;
    value = 16'h12AF;
    bright = 3'd7;
    enable = 1'b1;
    blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (an_n !== 4'hF || seg_n !== 7'h7F || frame !== 1'b0) begin
      failures++;
      $display("FAIL reset_vals an=%h seg=%h frame=%b required F/7F/0",
               an_n, seg_n, frame);
    end
    reset_n = 1'b1;
    first_frame = -1;
    for (int k = 0; k < 4; k++) begin
      low_cnt[k] = 0;
      an_seen[k] = 4'hF;
      seg_seen[k] = 7'h7F;
    end
    for (int c = 1; c <= 2 * FRAME; c++) begin
      @(negedge clk);
      checks++;
      if (an_n !== exp_an || seg_n !== exp_seg || frame !== exp_frame) begin
        failures++;
        $display("FAIL reset_model c=%0d an=%h/%h seg=%h/%h frame=%b/%b",
                 c, an_n, exp_an, seg_n, exp_seg, frame, exp_frame);
      end
      if (frame === 1'b1 && first_frame < 0) first_frame = c;
      if (c <= FRAME && an_n !== 4'hF) begin
        low_cnt[(c - 1) / SLOT]++;
        checks++;
        if (seg_n !== 7'h40) begin
          failures++;
          $display("FAIL frame0_zero c=%0d seg=%h required 40", c, seg_n);
        end
      end
      if (c > FRAME && an_n !== 4'hF) begin
        an_seen[(c - 1 - FRAME) / SLOT] = an_n;
        seg_seen[(c - 1 - FRAME) / SLOT] = seg_n;
      end
    end
    checks++;
    if (first_frame != FRAME) begin
      failures++;
      $display("FAIL first_frame got=%0d required %0d", first_frame, FRAME);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (low_cnt[k] != SLOT - GUARD) begin
        failures++;
        $display("FAIL low_cycles dig=%0d got=%0d required %0d",
                 k, low_cnt[k], SLOT - GUARD);
      end
      checks++;
      if (an_seen[k] !== an_req[k] || seg_seen[k] !== seg_req[k]) begin
        failures++;
        $display("FAIL frame1 dig=%0d an=%h/%h seg=%h/%h",
                 k, an_seen[k], an_req[k], seg_seen[k], seg_req[k]);
      end
    end
  endtask

  task automatic test_tear_free();
    logic [15:0] v;
    int lim;
    sync_boundary();
    @(negedge clk);
    repeat (SLOT + 5) @(negedge clk);
    value = 16'($urandom);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      checks++;
      if (an_n !== exp_an || seg_n !== exp_seg || frame !== exp_frame) begin
        failures++;
        $display("FAIL tear_mid n=%0d an=%h/%h seg=%h/%h frame=%b/%b",
                 n, an_n, exp_an, seg_n, exp_seg, frame, exp_frame);
      end
    end
    sync_boundary();
    v = 16'($urandom);
    value = v;
    @(negedge clk);
    value = ~v;
    lim = 0;
    while (an_n !== 4'hE && lim < FRAME) begin
      @(negedge clk);
      lim++;
    end
    checks++;
    if (an_n !== 4'hE || seg_n !== glyph_tab[v[3:0]]) begin
      failures++;
      $display("FAIL tear_boundary an=%h seg=%h required E/%h",
               an_n, seg_n, glyph_tab[v[3:0]]);
    end
  endtask

  task automatic test_lz();
    logic [15:0] vals [2];
    logic any_lit [4];
    logic [6:0] seg_lit [4];
    int od;
    vals = '{16'h0030, 16'h0000};
    bright = 3'd7;
    enable = 1'b1;
    for (int t = 0; t < 2; t++) begin
      sync_boundary();
      value = vals[t];
      blank_lz = 1'b1;
      @(negedge clk);
      value = 16'($urandom);
      blank_lz = 1'($urandom);
      for (int k = 0; k < 4; k++) begin
        any_lit[k] = 1'b0;
        seg_lit[k] = 7'h7F;
      end
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        od = ((n - 1) % FRAME) / SLOT;
        if (an_n !== 4'hF) begin
          any_lit[od] = 1'b1;
          seg_lit[od] = seg_n;
        end else begin
          checks++;
          if (seg_n !== 7'h7F) begin
            failures++;
            $display("FAIL lz_dark_seg dig=%0d seg=%h required 7F", od, seg_n);
          end
        end
      end
      checks++;
      if (any_lit[3] || any_lit[2] || !any_lit[0] || seg_lit[0] !== 7'h40) begin
        failures++;
        $display("FAIL lz_upper val=%h lit3=%b lit2=%b lit0=%b seg0=%h req 0/0/1/40",
                 vals[t], any_lit[3], any_lit[2], any_lit[0], seg_lit[0]);
      end
      checks++;
      if (t == 0 && (!any_lit[1] || seg_lit[1] !== 7'h30)) begin
        failures++;
        $display("FAIL lz_dig1 lit=%b seg=%h required 1/30", any_lit[1], seg_lit[1]);
      end
      if (t == 1 && any_lit[1]) begin
        failures++;
        $display("FAIL lz_zero_dig1 lit=%b required 0", any_lit[1]);
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_pwm();
    logic [2:0] levels [2];
    int req_tot [2];
    int s, p, tot;
    logic want;
    levels = '{3'd0, 3'd3};
    req_tot = '{4, 24};
    for (int t = 0; t < 2; t++) begin
      sync_boundary();
      value = 16'($urandom) | 16'h8000;
      bright = levels[t];
      enable = 1'b1;
      @(negedge clk);
      repeat (FRAME) @(negedge clk);
      tot = 0;
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        s = (n - 1) % SLOT;
        p = (n - 1) % 8;
        want = s >= GUARD && p <= int'(levels[t]);
        if (an_n !== 4'hF) tot++;
        checks++;
        if ((an_n !== 4'hF) !== want) begin
          failures++;
          $display("FAIL pwm b=%0d slot=%0d pwm=%0d an=%h required lit=%b",
                   levels[t], s, p, an_n, want);
        end
      end
      checks++;
      if (tot != req_tot[t]) begin
        failures++;
        $display("FAIL pwm_total b=%0d got=%0d required %0d",
                 levels[t], tot, req_tot[t]);
      end
    end
    bright = 3'd7;
  endtask

  task automatic test_enable();
    int last, gap;
    enable = 1'b1;
    bright = 3'd7;
    sync_boundary();
    repeat (SLOT + 7) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (an_n !== 4'hF || seg_n !== 7'h7F) begin
      failures++;
      $display("FAIL enable_off an=%h seg=%h required F/7F", an_n, seg_n);
    end
    last = -1;
    gap = -1;
    for (int c = 0; c < 3 * FRAME && gap < 0; c++) begin
      @(negedge clk);
      checks++;
      if (an_n !== exp_an || seg_n !== exp_seg || frame !== exp_frame) begin
        failures++;
        $display("FAIL enable_model n=%0d an=%h/%h seg=%h/%h frame=%b/%b",
                 n, an_n, exp_an, seg_n, exp_seg, frame, exp_frame);
      end
      if (frame === 1'b1) begin
        if (last >= 0) gap = c - last;
        last = c;
      end
    end
    checks++;
    if (gap != FRAME) begin
      failures++;
      $display("FAIL enable_frame_period got=%0d required %0d", gap, FRAME);
    end
    enable = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 6 * FRAME; c++) begin
      @(negedge clk);
      checks++;
      if (an_n !== exp_an || seg_n !== exp_seg || frame !== exp_frame) begin
        failures++;
        $display("FAIL random_model n=%0d an=%h/%h seg=%h/%h frame=%b/%b",
                 n, an_n, exp_an, seg_n, exp_seg, frame, exp_frame);
      end
      if ($urandom_range(0, 3) == 0) value = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 7) == 0) bright = 3'($urandom);
      enable = $urandom_range(0, 9) != 0;
    end
    enable = 1'b1;
    bright = 3'd7;
  endtask

  task automatic test_reset_mid();
    int lim;
    value = 16'h12AF;
    bright = 3'd7;
    enable = 1'b1;
    lim = 0;
    while (!(((n % FRAME) / SLOT) == 2 && (n % SLOT) == 8) && lim < 2 * FRAME) begin
      @(negedge clk);
      lim++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (an_n !== 4'hF || seg_n !== 7'h7F || frame !== 1'b0) begin
      failures++;
      $display("FAIL reset_async an=%h seg=%h frame=%b required F/7F/0",
               an_n, seg_n, frame);
    end
    @(negedge clk);
    reset_n = 1'b1;
    lim = 0;
    do begin
      @(negedge clk);
      lim++;
    end while (an_n === 4'hF && lim < SLOT);
    checks++;
    if (lim != GUARD + 1 || an_n !== 4'hE || seg_n !== 7'h40) begin
      failures++;
      $display("FAIL reset_restart cyc=%0d an=%h seg=%h required %0d/E/40",
               lim, an_n, seg_n, GUARD + 1);
    end
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      checks++;
      if (an_n !== exp_an || seg_n !== exp_seg || frame !== exp_frame) begin
        failures++;
        $display("FAIL restart_model n=%0d an=%h/%h seg=%h/%h frame=%b/%b",
                 n, an_n, exp_an, seg_n, exp_seg, frame, exp_frame);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tear_free();
    test_lz();
    test_pwm();
    test_enable();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sseg_scan_driver.md
# sseg_scan_driver

Time-multiplexed four-digit seven-segment scan driver. It sits directly downstream of the 16-bit seven-segment PIO and takes that PIO's `out_port` value as four hex nibbles. It drives the board's common-anode digit enables and shared segment lines, with:
- a tear-free frame-latched shadow copy of the value,
- optional leading-zero blanking,
- an anti-ghosting guard gap between digits,
- 8-level PWM brightness.

## Interface
Parameters:
- `SLOT_CYCLES`, default 50000: clk cycles per digit slot. Legal range is `GUARD_CYCLES`+2 .. 65535.
- `GUARD_CYCLES`, default 8: cycles at the start of each slot with all anodes off (ghosting guard). Legal range is 1 .. `SLOT_CYCLES`-2.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `value_i` in 16: value to display. Digit k shows `value_i[4k+3:4k]`; digit 0 is the rightmost, least significant digit.
- `blank_lz_i` in 1: 1 = blank leading zero digits.
- `bright_i` in 3: brightness; 0 = 1/8 duty, 7 = full duty within the active window.
- `enable_i` in 1: 0 = display dark. Counters keep running.
- `seg_n_o` out 7: active-low segments {g,f,e,d,c,b,a}.
- `an_n_o` out 4: active-low digit anodes; bit k drives digit k.
- `frame_o` out 1: one-cycle pulse at each frame boundary.

## Operation
State:
- `slot_cnt` (16 b) counts 0..`SLOT_CYCLES`-1, then wraps to 0.
- `dig` (2 b) increments when `slot_cnt` wraps, 3→0.
- `pwm_cnt` (3 b) is free-running and increments every cycle.
- `shadow` (16 b) and `lz_q` (1 b) hold the latched display value and latched blanking flag.

Frame boundary (the cycle where `slot_cnt`=`SLOT_CYCLES`-1 and `dig`=3):
- On that clock edge, `shadow` ← `value_i` and `lz_q` ← `blank_lz_i`.
- `frame_o` is driven high during the following cycle (registered), for exactly one cycle per frame.
- `value_i` and `blank_lz_i` changes at any other time have no visible effect until the next frame boundary.

Digit k is blank when any of the following holds:
- `enable_i`=0;
- `lz_q`=1, k≠0, and `shadow` nibbles k..3 are all zero.

Digit 0 is never leading-zero blanked.

Anode condition: `an_n_o[dig]`=0 only when all of these hold:
- the digit is not blank;
- `slot_cnt` ≥ `GUARD_CYCLES`;
- `pwm_cnt` ≤ `bright_i`.

All other anode bits are 1. At most one anode is ever low.

Segment output:
- `seg_n_o` carries the hex glyph of `shadow` nibble `dig`.
- It is 7'h7F whenever the anode is off.
- Glyphs, 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).

`bright_i` and `enable_i` are sampled live, not frame-latched.

## Timing
- All outputs are registered. `seg_n_o`, `an_n_o` and `frame_o` at cycle t+1 reflect counter and input state at cycle t.
- Reset values (asserted asynchronously, any time, including mid-slot):
  - `an_n_o`=4'hF, `seg_n_o`=7'h7F, `frame_o`=0;
  - `slot_cnt`=0, `dig`=0, `pwm_cnt`=0, `shadow`=0, `lz_q`=0.
- After reset release:
  - Digit 0 scans first, showing "0" with shadow=0.
  - The first anode assertion occurs in the cycle after `slot_cnt` reaches `GUARD_CYCLES`.
  - The first frame boundary occurs at cycle 4·`SLOT_CYCLES`-1 after release.
- Frame period is exactly 4·`SLOT_CYCLES` cycles.
- Digit change: on `dig` advance, the anodes are already off for the `GUARD_CYCLES` window, so segment lines switch while dark.
- Simultaneous events:
  - a `value_i` change on the frame-boundary cycle is captured;
  - an `enable_i` fall takes effect on the next output cycle regardless of the slot position.
- Counter arithmetic is unsigned. `slot_cnt` never exceeds `SLOT_CYCLES`-1.

## Test plan
Bench parameters: `SLOT_CYCLES`=16, `GUARD_CYCLES`=2.

- Reset behaviour:
  - Stimulus: reset, release; `value_i`=16'h12AF, `bright_i`=7, `enable_i`=1, `blank_lz_i`=0.
  - Required: frame 0 shows "0000".
  - Required: `frame_o` pulses at cycle 64 after release, and the following frame shows `an_n_o` E,D,B,7 with `seg_n_o` 0E,08,24,79.
  - Required: each anode is low for 14 cycles per 16-cycle slot.
- Tear-free latching:
  - Stimulus: change `value_i` mid-frame.
  - Required: displayed digits are unchanged until after the next `frame_o`.
  - Required: a change on the boundary cycle itself is shown in the next frame.
- Leading-zero blanking:
  - Stimulus: `blank_lz_i`=1 with `value_i`=16'h0030.
  - Required: digits 3 and 2 are dark (anodes high, segments 7F); digit 1 shows 30; digit 0 shows 40.
  - Stimulus: `value_i`=0.
  - Required: only digit 0 is lit, showing "0".
- Brightness PWM:
  - Stimulus: `bright_i`=0.
  - Required: within the active window, the anode is low exactly on cycles where `pwm_cnt`=0 (1 of every 8).
  - Stimulus: `bright_i`=3.
  - Required: the anode is low on 4 of every 8 cycles.
  - Required: never low during guard cycles.
- Enable and one-hot anodes:
  - Stimulus: drop `enable_i` mid-slot.
  - Required: `an_n_o`=F and `seg_n_o`=7F on the next cycle; `frame_o` keeps its 64-cycle period.
  - Required (checked continuously by assertion): `an_n_o` never has more than one bit low.
- Reset mid-operation:
  - Stimulus: assert `reset_n` low asynchronously during digit 2's slot.
  - Required: outputs go to F/7F/0 without waiting for a clock edge; the scan restarts at digit 0 with shadow=0.
